pmem_arbiter: RTL and testbench

Single-port arbiter and scheduler for the 128-bit partial-sum / output SRAM (PMEM). Three requesters share the one SRAM port: the OFIFO drain writer, the SFU accumulate reader and the host readback port. The block grants one access per cycle, holds bursts, and drives the registered SRAM controls. It returns read data tagged to the requester that issued the read.

---
 rtl/pmem_arbiter_pkg.sv | 28 ++
 rtl/pmem_arbiter_if.sv | 28 ++
 rtl/pmem_arbiter_rr_pick.sv | 30 +++
 rtl/pmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_pmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types and constants for the PMEM single-port arbiter.
package pmem_arb_pkg;

    localparam int N_REQ   = 3;
    localparam int PMEM_DW = 128;

    typedef enum logic [1:0] {
        REQ_OFIFO = 2'd0,
        REQ_SFU   = 2'd1,
        REQ_HOST  = 2'd2
    } req_id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Round-robin search starts at the requester after the one just chosen.
    function automatic req_id_t next_ptr(input logic [N_REQ-1:0] winner);
        req_id_t nxt;
        nxt = REQ_OFIFO;
        if (winner[0]) nxt = REQ_SFU;
        if (winner[1]) nxt = REQ_HOST;
        if (winner[2]) nxt = REQ_OFIFO;
        return nxt;
    endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Requester-side bus of the PMEM arbiter: packed requests in, grants and read returns out.
interface pmem_arbiter_if
    import pmem_arb_pkg::*;
#(
    parameter int addr_bw = 9,
    parameter int dw      = PMEM_DW
) ();

    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         req_wr;
    logic [N_REQ*addr_bw-1:0] req_addr;
    logic [N_REQ*dw-1:0]      req_d;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rvalid;
    logic [dw-1:0]            rdata;
    logic                     busy;

    modport master (
        output req, req_wr, req_addr, req_d,
        input  gnt, rvalid, rdata, busy
    );

    modport slave (
        input  req, req_wr, req_addr, req_d,
        output gnt, rvalid, rdata, busy
    );

endinterface

// File: rtl/pmem_arbiter_rr_pick.sv
// 3-way masked priority picker: first requester not excluded, searching upward from ptr.
module rr_pick
    import pmem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] excl,
    input  logic [1:0]       ptr,
    output logic [N_REQ-1:0] win
);

    logic [N_REQ-1:0] cand;
    logic [2:0]       pos;
    logic             found;

    always_comb begin
        cand  = req & ~excl;
        win   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr} + 3'(k);
            if (pos >= 3'(N_REQ)) pos = pos - 3'(N_REQ);
            if (!found && cand[pos[1:0]]) begin
                win[pos[1:0]] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Single-port PMEM arbiter: burst-holding grant FSM, registered SRAM drive, tagged read return.
// Define PMEM_ARB_RR_EN for round-robin selection; otherwise fixed priority OFIFO > SFU > host.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int psum_bw   = 16,
    parameter int col       = 8,
    parameter int addr_bw   = 9,
    parameter int max_burst = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pmem_arbiter_if.slave          bus,
    input  logic [col*psum_bw-1:0] OP_q,
    output logic [col*psum_bw-1:0] OP_d,
    output logic [addr_bw-1:0]     OP_addr,
    output logic                   OP_cen,
    output logic                   OP_wen
);

    localparam int DW    = col * psum_bw;
    localparam int CNT_W = $clog2(max_burst + 1);

    arb_state_t       state;
    logic [N_REQ-1:0] owner;
    logic [CNT_W-1:0] burst_cnt;
    logic [1:0]       ptr;

    logic [N_REQ-1:0] pick_excl;
    logic [N_REQ-1:0] pick_win;
    logic [N_REQ-1:0] gnt_c;
    logic [N_REQ-1:0] others;
    logic             owner_req;
    logic             at_limit;
    logic             new_owner;

    logic               sel_wr;
    logic [addr_bw-1:0] sel_addr;
    logic [DW-1:0]      sel_d;

    logic [N_REQ-1:0] rd_tag0;
    logic [N_REQ-1:0] rd_tag1;

    assign owner_req = |(bus.req & owner);
    assign at_limit  = (burst_cnt == CNT_W'(max_burst));
    assign others    = bus.req & ~owner;
    // Only a preempting selection excludes the current owner.
    assign pick_excl = (state == BURST && owner_req && at_limit) ? owner : '0;

    rr_pick u_pick (
        .req  (bus.req),
        .excl (pick_excl),
        .ptr  (ptr),
        .win  (pick_win)
    );

    always_comb begin
        gnt_c     = '0;
        new_owner = 1'b0;
        if (state == IDLE || !owner_req) begin
            gnt_c     = pick_win;
            new_owner = |bus.req;
        end else if (!at_limit || others == '0) begin
            gnt_c = owner;
        end else begin
            gnt_c     = pick_win;
            new_owner = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
        end else if (gnt_c == '0) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state <= BURST;
            owner <= gnt_c;
            if (new_owner || at_limit)
                burst_cnt <= CNT_W'(1);
            else
                burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end

`ifdef PMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= 2'd0;
        else if (new_owner)
            ptr <= next_ptr(gnt_c);
    end
`else
    assign ptr = 2'd0;
`endif

    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_d    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_wr   = bus.req_wr[i];
                sel_addr = bus.req_addr[i*addr_bw +: addr_bw];
                sel_d    = bus.req_d[i*DW +: DW];
            end
        end
    end

    // Address and data hold across idle cycles; only the enables park high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            OP_cen  <= 1'b1;
            OP_wen  <= 1'b1;
            OP_addr <= '0;
            OP_d    <= '0;
        end else if (gnt_c != '0) begin
            OP_cen  <= 1'b0;
            OP_wen  <= !sel_wr;
            OP_addr <= sel_addr;
            OP_d    <= sel_d;
        end else begin
            OP_cen <= 1'b1;
            OP_wen <= 1'b1;
        end
    end

    // Tag follows the access: registered with OP_*, then aligned with OP_q one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_tag0 <= '0;
            rd_tag1 <= '0;
        end else begin
            rd_tag0 <= gnt_c & ~bus.req_wr;
            rd_tag1 <= rd_tag0;
        end
    end

    assign bus.gnt    = reset ? gnt_c : '0;
    assign bus.busy   = (state == BURST);
    assign bus.rvalid = rd_tag1;
    assign bus.rdata  = OP_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter with a synchronous SRAM model on the OP_* port.
module tb_pmem_arbiter;

    localparam logic [127:0] HOST_DATA = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_ABCD;
    localparam logic [127:0] WR_DATA   = 128'hCAFE_0001_BEEF_0002_DEAD_0003_F00D_0004;

    logic         clk;
    logic         reset;
    logic [127:0] OP_q;
    logic [127:0] OP_d;
    logic [8:0]   OP_addr;
    logic         OP_cen;
    logic         OP_wen;

    logic [127:0] mem [0:511];

    int n_checks = 0;
    int n_fail   = 0;

    pmem_arbiter_if bus ();

    pmem_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .OP_q    (OP_q),
        .OP_d    (OP_d),
        .OP_addr (OP_addr),
        .OP_cen  (OP_cen),
        .OP_wen  (OP_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM: one access per edge while OP_cen is low.
    always @(posedge clk) begin
        if (!OP_cen) begin
            if (!OP_wen)
                mem[OP_addr] <= OP_d;
            else
                OP_q <= mem[OP_addr];
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [8:0] addr,
                           input logic [127:0] d);
        bus.req_wr[i]            = wr;
        bus.req_addr[i*9 +: 9]   = addr;
        bus.req_d[i*128 +: 128]  = d;
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        bus.req      = 3'b000;
        bus.req_wr   = '0;
        bus.req_addr = '0;
        bus.req_d    = '0;
        #1 reset     = 1'b0;
        bus.req      = 3'b111;
        #1;
        n_checks++;
        if ({OP_cen, OP_wen} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL reset_enables: got %b, want 11", {OP_cen, OP_wen});
        end
        n_checks++;
        if (OP_addr !== 9'h000 || OP_d !== 128'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_addr_data: got addr %h data %h, want 0", OP_addr, OP_d);
        end
        n_checks++;
        if ({bus.gnt, bus.rvalid, bus.busy} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_gnt_rvalid_busy: got %b, want 0000000",
                     {bus.gnt, bus.rvalid, bus.busy});
        end
        bus.req = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({OP_cen, OP_wen, bus.gnt, bus.busy, bus.rvalid} !== 9'b11_000_0_000) begin
                n_fail++;
                $display("[TB] FAIL idle_after_reset cycle %0d: got %b, want 110000000", n,
                         {OP_cen, OP_wen, bus.gnt, bus.busy, bus.rvalid});
            end
        end
    endtask

    task automatic test_host_read;
        @(negedge clk);
        set_req(2, 1'b0, 9'h005, '0);
        bus.req = 3'b100;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL host_gnt: got %b, want 100", bus.gnt);
        end
        @(negedge clk);
        bus.req = 3'b000;
        #1;
        n_checks++;
        if ({OP_cen, OP_wen, OP_addr} !== {2'b01, 9'h005}) begin
            n_fail++;
            $display("[TB] FAIL host_sram_drive: got cen %b wen %b addr %h, want 0 1 005",
                     OP_cen, OP_wen, OP_addr);
        end
        n_checks++;
        if ({bus.gnt, bus.rvalid} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL host_t1_quiet: got gnt %b rvalid %b, want 000 000",
                     bus.gnt, bus.rvalid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.rvalid !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL host_rvalid: got %b, want 100", bus.rvalid);
        end
        n_checks++;
        if (bus.rdata !== HOST_DATA) begin
            n_fail++;
            $display("[TB] FAIL host_rdata: got %h, want %h", bus.rdata, HOST_DATA);
        end
        n_checks++;
        if ({OP_cen, OP_wen, OP_addr} !== {2'b11, 9'h005}) begin
            n_fail++;
            $display("[TB] FAIL host_idle_hold: got cen %b wen %b addr %h, want 1 1 005",
                     OP_cen, OP_wen, OP_addr);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.rvalid !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL host_rvalid_single: got %b, want 000", bus.rvalid);
        end
    endtask

    task automatic test_write_then_read;
        @(negedge clk);
        set_req(0, 1'b1, 9'h010, WR_DATA);
        set_req(1, 1'b0, 9'h010, '0);
        bus.req = 3'b001;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL wr_gnt: got %b, want 001", bus.gnt);
        end
        @(negedge clk);
        bus.req = 3'b010;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL rd_gnt_no_gap: got %b, want 010", bus.gnt);
        end
        n_checks++;
        if ({OP_cen, OP_wen, OP_addr} !== {2'b00, 9'h010} || OP_d !== WR_DATA) begin
            n_fail++;
            $display("[TB] FAIL wr_sram_drive: got cen %b wen %b addr %h d %h, want 0 0 010 %h",
                     OP_cen, OP_wen, OP_addr, OP_d, WR_DATA);
        end
        @(negedge clk);
        bus.req = 3'b000;
        #1;
        n_checks++;
        if ({OP_cen, OP_wen, bus.rvalid} !== 5'b01_000) begin
            n_fail++;
            $display("[TB] FAIL rd_sram_drive: got cen %b wen %b rvalid %b, want 0 1 000",
                     OP_cen, OP_wen, bus.rvalid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.rvalid !== 3'b010 || bus.rdata !== WR_DATA) begin
            n_fail++;
            $display("[TB] FAIL raw_return: got rvalid %b rdata %h, want 010 %h",
                     bus.rvalid, bus.rdata, WR_DATA);
        end
    endtask

    task automatic test_burst_rotation;
        logic [2:0] exp_seq [3];
`ifdef PMEM_ARB_RR_EN
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b010;
        exp_seq[2] = 3'b100;
`else
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b010;
        exp_seq[2] = 3'b001;
`endif
        for (int i = 0; i < 3; i++)
            set_req(i, 1'b1, 9'h020 + 9'(i), 128'(i + 1));
        for (int n = 0; n < 48; n++) begin
            @(negedge clk);
            bus.req = 3'b111;
            #1;
            n_checks++;
            if (bus.gnt !== exp_seq[n/16]) begin
                n_fail++;
                $display("[TB] FAIL burst_grant %0d: got %b, want %b", n, bus.gnt, exp_seq[n/16]);
            end
        end
        @(negedge clk);
        bus.req = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_long_burst;
        set_req(0, 1'b1, 9'h030, WR_DATA);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            bus.req = 3'b001;
            #1;
            n_checks++;
            if (bus.gnt !== 3'b001 || bus.busy !== (n != 0)) begin
                n_fail++;
                $display("[TB] FAIL long_burst %0d: got gnt %b busy %b, want 001 %b",
                         n, bus.gnt, bus.busy, (n != 0));
            end
        end
        @(negedge clk);
        bus.req = 3'b000;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL burst_drop: got gnt %b busy %b, want 000 1", bus.gnt, bus.busy);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL burst_end_idle: got busy %b, want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        set_req(1, 1'b0, 9'h005, '0);
        bus.req = 3'b010;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL mid_read_gnt: got %b, want 010", bus.gnt);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({OP_cen, OP_wen} !== 2'b11 || OP_addr !== 9'h000 || OP_d !== 128'h0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_sram: got cen %b wen %b addr %h d %h, want 1 1 000 0",
                     OP_cen, OP_wen, OP_addr, OP_d);
        end
        n_checks++;
        if ({bus.gnt, bus.busy, bus.rvalid} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_ctrl: got gnt %b busy %b rvalid %b, want 000 0 000",
                     bus.gnt, bus.busy, bus.rvalid);
        end
        bus.req = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({bus.rvalid, OP_cen, bus.gnt} !== 7'b000_1_000) begin
                n_fail++;
                $display("[TB] FAIL post_reset_quiet %0d: got rvalid %b cen %b gnt %b, want 000 1 000",
                         n, bus.rvalid, OP_cen, bus.gnt);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 512; a++)
            mem[a] = 128'h0;
        mem[9'h005] = HOST_DATA;
        mem[9'h010] = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
        test_reset();
        test_host_read();
        test_write_then_read();
        repeat (2) @(negedge clk);
        test_burst_rotation();
        test_long_burst();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
